sort4_ctrl: RTL and testbench

Sequential sorter for four 4-bit unsigned values that time-shares a single instance of the team's 4-bit `comparator` module (outputs `x_gt_y`, `x_eq_y`, `x_lt_y`). A small FSM walks a fixed bubble-sort schedule of six compare/swap steps, one step per clock. It uses a start/done handshake and reports the number of swaps performed. It sits between a register-file/operand source and any consumer that needs ordered nibbles, for example a min/max or median stage.

---
 rtl/sort4_ctrl.sv | 134 +++++++++++++
 tb/tb_sort4_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sort4_ctrl.sv
// Sequential 4x4-bit sorter: a small FSM walks a fixed six-step bubble-sort
// schedule, time-sharing one 4-bit magnitude comparator.

module comparator (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic       x_gt_y,
    output logic       x_eq_y,
    output logic       x_lt_y
);
    assign x_gt_y = (x > y);
    assign x_eq_y = (x == y);
    assign x_lt_y = (x < y);
endmodule

module sort4_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        desc,
    input  logic [15:0] din,
    output logic        busy,
    output logic        done,
    output logic [15:0] dout,
    output logic [2:0]  swap_cnt
);
    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

    state_t     state;
    logic [2:0] step;
    logic [3:0] r0, r1, r2, r3;
    logic [3:0] n0, n1, n2, n3;
    logic       mode;
    logic [2:0] cnt;
    logic [3:0] cmp_x, cmp_y;
    logic       x_gt_y, x_eq_y, x_lt_y;
    logic       swap;

    comparator u_cmp (
        .x      (cmp_x),
        .y      (cmp_y),
        .x_gt_y (x_gt_y),
        .x_eq_y (x_eq_y),
        .x_lt_y (x_lt_y)
    );

    // Pair schedule: (0,1) (1,2) (2,3) (0,1) (1,2) (0,1)
    always_comb begin
        cmp_x = r0;
        cmp_y = r1;
        case (step)
            3'd1, 3'd4: begin cmp_x = r1; cmp_y = r2; end
            3'd2:       begin cmp_x = r2; cmp_y = r3; end
            default:    begin cmp_x = r0; cmp_y = r1; end
        endcase
    end

    // Equal elements never swap, keeping the sort stable.
    assign swap = !x_eq_y && (mode ? x_lt_y : x_gt_y);

    always_comb begin
        n0 = r0;
        n1 = r1;
        n2 = r2;
        n3 = r3;
        if (swap) begin
            case (step)
                3'd1, 3'd4: begin n1 = r2; n2 = r1; end
                3'd2:       begin n2 = r3; n3 = r2; end
                default:    begin n0 = r1; n1 = r0; end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            step     <= '0;
            r0       <= '0;
            r1       <= '0;
            r2       <= '0;
            r3       <= '0;
            mode     <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dout     <= '0;
            swap_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r0    <= din[3:0];
                        r1    <= din[7:4];
                        r2    <= din[11:8];
                        r3    <= din[15:12];
                        mode  <= desc;
                        step  <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SORT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                SORT: begin
                    r0  <= n0;
                    r1  <= n1;
                    r2  <= n2;
                    r3  <= n3;
                    cnt <= cnt + {2'b00, swap};
                    if (step == 3'd5) begin
                        // Publish the post-swap values of the last step directly.
                        dout     <= {n3, n2, n1, n0};
                        swap_cnt <= cnt + {2'b00, swap};
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        step     <= '0;
                        state    <= DONE;
                    end else begin
                        step <= step + 3'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sort4_ctrl.sv
// Self-checking bench for sort4_ctrl: table vectors, random vectors against a
// rank-based reference model, and hand-written handshake/reset sequences.

module tb_sort4_ctrl;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic        desc;
    logic [15:0] din;
    logic        busy;
    logic        done;
    logic [15:0] dout;
    logic [2:0]  swap_cnt;

    typedef struct {
        logic [15:0] din;
        logic        desc;
        logic [15:0] exp_dout;
        logic [2:0]  exp_cnt;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        logic [2:0]  c;
    } sb_t;

    sb_t         sb_q[$];
    logic [15:0] prev_dout;
    int          n_cmp;
    int          n_err;

    sort4_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .desc     (desc),
        .din      (din),
        .busy     (busy),
        .done     (done),
        .dout     (dout),
        .swap_cnt (swap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Rank-based reference: element i lands at (#elements strictly ahead of it
    // + #equal elements with lower index); swaps of a full bubble sort equal
    // the number of strict inversions.
    function automatic sb_t model(input logic [15:0] d, input logic ds);
        logic [3:0] e[4];
        logic [3:0] o[4];
        int unsigned inv;
        int unsigned rank;
        sb_t res;
        inv = 0;
        for (int i = 0; i < 4; i++) e[i] = d[4*i +: 4];
        for (int i = 0; i < 4; i++) begin
            rank = 0;
            for (int j = 0; j < 4; j++) begin
                if (ds ? (e[j] > e[i]) : (e[j] < e[i])) rank++;
                else if (e[j] == e[i] && j < i) rank++;
                if (j > i && (ds ? (e[i] < e[j]) : (e[i] > e[j]))) inv++;
            end
            o[rank] = e[i];
        end
        res.d = {o[3], o[2], o[1], o[0]};
        res.c = inv[2:0];
        return res;
    endfunction

    task automatic drive_start(input logic [15:0] d, input logic ds, input sb_t exp);
        start = 1'b1;
        din   = d;
        desc  = ds;
        sb_q.push_back(exp);
    endtask

    // Called right after start is driven (between edges). Expects done on the
    // 7th sample after the start edge, busy for 6 samples, dout held meanwhile.
    task automatic wait_done(input string tag, input bit hold_start, input bit pulse_mid);
        int  lat;
        int  busy_n;
        sb_t e;
        lat    = 0;
        busy_n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1 && !hold_start) start = 1'b0;
            if (pulse_mid) begin
                if (i == 2 || i == 4) begin
                    start = 1'b1;
                    din   = 16'($urandom);
                    desc  = ~desc;
                end else if (i == 3 || i == 5) begin
                    start = 1'b0;
                end
            end
            if (busy) busy_n++;
            if (done) begin
                lat = i;
                break;
            end
            check({tag, "_hold"}, {16'h0, dout}, {16'h0, prev_dout});
        end
        check({tag, "_latency"}, lat, 7);
        check({tag, "_busy_cycles"}, busy_n, 6);
        check({tag, "_busy_at_done"}, {31'h0, busy}, 0);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_dout"}, {16'h0, dout}, {16'h0, e.d});
            check({tag, "_swap_cnt"}, {29'h0, swap_cnt}, {29'h0, e.c});
            prev_dout = e.d;
        end
    endtask

    initial begin
        vec_t tbl[7];
        vec_t v;
        sb_t  m;
        sb_t  m2;
        int   extra;
        logic [15:0] rd;
        logic        rds;

        tbl[0] = '{16'h0213, 1'b0, 16'h3210, 3'd5};
        tbl[1] = '{16'h05AF, 1'b0, 16'hFA50, 3'd6};
        tbl[2] = '{16'h3210, 1'b0, 16'h3210, 3'd0};
        tbl[3] = '{16'h9277, 1'b1, 16'h2779, 3'd3};
        tbl[4] = '{16'h3210, 1'b1, 16'h0123, 3'd6};
        tbl[5] = '{16'h5555, 1'b0, 16'h5555, 3'd0};
        tbl[6] = '{16'h088F, 1'b1, 16'h088F, 3'd0};

        n_cmp     = 0;
        n_err     = 0;
        prev_dout = 16'h0;
        rst_n     = 1'b0;
        start     = 1'b0;
        desc      = 1'b0;
        din       = 16'h0;

        repeat (2) @(negedge clk);
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_done", {31'h0, done}, 0);
        check("rst_dout", {16'h0, dout}, 0);
        check("rst_swap_cnt", {29'h0, swap_cnt}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 7; k++) begin
            v = tbl[k];
            m.d = v.exp_dout;
            m.c = v.exp_cnt;
            drive_start(v.din, v.desc, m);
            wait_done($sformatf("tbl%0d", k), 1'b0, 1'b0);
            @(negedge clk);
        end

        for (int k = 0; k < 8; k++) begin
            rd  = 16'($urandom);
            rds = 1'($urandom_range(1, 0));
            drive_start(rd, rds, model(rd, rds));
            wait_done($sformatf("rnd%0d", k), 1'b0, 1'b0);
            @(negedge clk);
        end

        // start pulses during SORT must be ignored; only one done expected
        m.d = 16'h3210;
        m.c = 3'd5;
        drive_start(16'h0213, 1'b0, m);
        wait_done("ignore_start", 1'b0, 1'b1);
        start = 1'b0;
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("ignore_extra_done", extra, 0);
        check("ignore_dout_kept", {16'h0, dout}, 32'h3210);

        // start held high through DONE: back-to-back sorts
        m.d = 16'hFA50;
        m.c = 3'd6;
        drive_start(16'h05AF, 1'b0, m);
        wait_done("b2b_first", 1'b1, 1'b0);
        m2.d = 16'h2779;
        m2.c = 3'd3;
        drive_start(16'h9277, 1'b1, m2);
        wait_done("b2b_second", 1'b0, 1'b0);
        @(negedge clk);

        // asynchronous reset mid-sort (step 3)
        start = 1'b1;
        din   = 16'h05AF;
        desc  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'h0, busy}, 0);
        check("abort_done", {31'h0, done}, 0);
        check("abort_dout", {16'h0, dout}, 0);
        check("abort_swap_cnt", {29'h0, swap_cnt}, 0);
        prev_dout = 16'h0;
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) extra++;
        end
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("abort_no_done", extra, 0);

        m.d = 16'h3210;
        m.c = 3'd5;
        drive_start(16'h0213, 1'b0, m);
        wait_done("after_abort", 1'b0, 1'b0);
        @(negedge clk);

        check("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
